// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: divide counter, start/stop/drain sequencing and
// glitch-free divisor changes via valid/ready. Optional CLK_DIV_CTRL_STATUS_EN adds periodCntOut.
module clk_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             enIn,
  input  logic             divValidIn,
  input  logic [CNT_W-1:0] divDataIn,
  output logic             divReadyOut,
  output logic             divErrOut,
  output logic             clkOut,
  output logic             riseOut,
  output logic             fallOut,
  output logic             busyOut,
`ifdef CLK_DIV_CTRL_STATUS_EN
  output logic [CNT_W-1:0] periodCntOut,
`endif
  output logic [CNT_W-1:0] divCurOut
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_cur_q, div_cur_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               clk_q, clk_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               accept;
  logic               tc;
`ifdef CLK_DIV_CTRL_STATUS_EN
  logic [CNT_W-1:0]   period_q, period_d;
`endif

  assign accept = divValidIn && !busy_q;
  assign tc     = (cnt_q == div_cur_q - CNT_W'(1));

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = 1'b0;
`ifdef CLK_DIV_CTRL_STATUS_EN
    period_d  = period_q;
`endif

    // Accept and apply never coincide: accept needs !busy_q, apply needs busy_q.
    if (accept) begin
      if (divDataIn == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d = divDataIn;
        busy_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (busy_q) begin
          div_cur_d = pend_q;
          busy_d    = 1'b0;
        end
        if (enIn) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (!enIn && !clk_q) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else begin
          state_d = enIn ? ST_RUN : ST_DRAIN;
          if (tc) begin
            cnt_d  = '0;
            clk_d  = !clk_q;
            rise_d = !clk_q;
            fall_d = clk_q;
            if (clk_q) begin
              // A falling toggle is the only safe point to switch divisor or stop.
              if (busy_q) begin
                div_cur_d = pend_q;
                busy_d    = 1'b0;
              end
              if (!enIn) state_d = ST_STOP;
`ifdef CLK_DIV_CTRL_STATUS_EN
              period_d = period_q + CNT_W'(1);
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      div_cur_q <= CNT_W'(DEFAULT_DIV);
      pend_q    <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CLK_DIV_CTRL_STATUS_EN
      period_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef CLK_DIV_CTRL_STATUS_EN
      period_q  <= period_d;
`endif
    end
  end

  assign divReadyOut = !busy_q;
  assign divErrOut   = err_q;
  assign clkOut      = clk_q;
  assign riseOut     = rise_q;
  assign fallOut     = fall_q;
  assign busyOut     = busy_q;
  assign divCurOut   = div_cur_q;
`ifdef CLK_DIV_CTRL_STATUS_EN
  assign periodCntOut = period_q;
`endif

endmodule
